// File: rtl/memory_responder.sv
// Word-addressed RAM target for the CPU memory port, with a boot-load port and a
// fixed-latency registered read pipeline that returns data in issue order.
module memory_responder #(
  parameter int WORD_SIZE     = 16,
  parameter int MEM_ADDR_SIZE = 5,
  parameter int READ_LATENCY  = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [MEM_ADDR_SIZE-1:0] mem_address,
  input  logic [WORD_SIZE-1:0]     mem_write_data,
  input  logic                     mem_read,
  input  logic                     mem_write,
  output logic [WORD_SIZE-1:0]     mem_read_data,
  output logic                     mem_ready,
  input  logic                     load_mode,
  input  logic                     load_valid,
  input  logic [WORD_SIZE-1:0]     load_data,
  output logic                     load_full,
  output logic                     access_error
);

  localparam int DEPTH = 2 ** MEM_ADDR_SIZE;

  generate
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
      $error("memory_responder: READ_LATENCY must be in 1..4");
    end
  endgenerate

  logic [WORD_SIZE-1:0]     mem [DEPTH];
  logic [MEM_ADDR_SIZE-1:0] load_ptr;
  logic [READ_LATENCY-1:0]  pipe_valid;
  logic [WORD_SIZE-1:0]     pipe_data [READ_LATENCY];

  logic                     read_issue;
  logic                     illegal;
  logic                     ram_we;
  logic [MEM_ADDR_SIZE-1:0] ram_waddr;
  logic [WORD_SIZE-1:0]     ram_wdata;

  // A simultaneous read+write keeps the write and drops the read.
  assign read_issue = !load_mode && mem_read && !mem_write;
  assign illegal    = load_mode ? (mem_read || mem_write) : (mem_read && mem_write);

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = mem_address;
    ram_wdata = mem_write_data;
    if (reset) begin
      if (load_mode) begin
        ram_we    = load_valid;
        ram_waddr = load_ptr;
        ram_wdata = load_data;
      end else begin
        ram_we    = mem_write;
      end
    end
  end

  // RAM contents deliberately survive reset so a loaded image persists.
  always_ff @(posedge clock) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
  end

  // Data stages only advance behind a valid bit, so the last stage holds the
  // most recent return until the next one arrives.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pipe_valid <= '0;
      for (int k = 0; k < READ_LATENCY; k++) pipe_data[k] <= '0;
    end else if (load_mode) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid[0] <= read_issue;
      if (read_issue) pipe_data[0] <= mem[mem_address];
      for (int k = 1; k < READ_LATENCY; k++) begin
        pipe_valid[k] <= pipe_valid[k-1];
        if (pipe_valid[k-1]) pipe_data[k] <= pipe_data[k-1];
      end
    end
  end

  assign mem_read_data = pipe_data[READ_LATENCY-1];
  assign mem_ready     = pipe_valid[READ_LATENCY-1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      load_ptr     <= '0;
      load_full    <= 1'b0;
      access_error <= 1'b0;
    end else begin
      if (illegal) access_error <= 1'b1;
      if (load_mode) begin
        if (load_valid) begin
          load_ptr <= load_ptr + 1'b1;
          if (load_ptr == '1) load_full <= 1'b1;
        end
      end else begin
        load_ptr  <= '0;
        load_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: boot load, RUN reads/writes, read-before-write
// ordering, illegal accesses, back-to-back reads and asynchronous reset.
module tb_memory_responder;

  localparam int W   = 16;
  localparam int A   = 5;
  localparam int LAT = 3;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [A-1:0] mem_address = '0;
  logic [W-1:0] mem_write_data = '0;
  logic         mem_read = 1'b0;
  logic         mem_write = 1'b0;
  logic [W-1:0] mem_read_data;
  logic         mem_ready;
  logic         load_mode = 1'b0;
  logic         load_valid = 1'b0;
  logic [W-1:0] load_data = '0;
  logic         load_full;
  logic         access_error;

  int total = 0;
  int bad   = 0;

  memory_responder #(.WORD_SIZE(W), .MEM_ADDR_SIZE(A), .READ_LATENCY(LAT)) dut (
    .clock          (clock),
    .reset          (reset),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_read_data  (mem_read_data),
    .mem_ready      (mem_ready),
    .load_mode      (load_mode),
    .load_valid     (load_valid),
    .load_data      (load_data),
    .load_full      (load_full),
    .access_error   (access_error)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_word(input logic [W-1:0] d);
    load_mode  = 1'b1;
    load_valid = 1'b1;
    load_data  = d;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic write_word(input logic [A-1:0] a, input logic [W-1:0] d);
    mem_write      = 1'b1;
    mem_address    = a;
    mem_write_data = d;
    tick();
    mem_write      = 1'b0;
  endtask

  task automatic read_word(input string tag, input logic [A-1:0] a, input logic [W-1:0] exp);
    int n = 0;
    mem_read    = 1'b1;
    mem_address = a;
    tick();
    mem_read    = 1'b0;
    while (!mem_ready && n < 8) begin
      tick();
      n++;
    end
    check_val({tag, "_lat"}, n, LAT - 1);
    check_val({tag, "_data"}, mem_read_data, exp);
    tick();
    check_val({tag, "_pulse"}, mem_ready, 0);
  endtask

  initial begin
    int seen;
    logic [W-1:0] exp5 [4];
    exp5[0] = 16'hBEEF; exp5[1] = 16'h1001; exp5[2] = 16'h1002; exp5[3] = 16'h1003;

    // reset state
    repeat (2) tick();
    check_val("rst_data", mem_read_data, 0);
    check_val("rst_ready", mem_ready, 0);
    check_val("rst_full", load_full, 0);
    check_val("rst_err", access_error, 0);
    reset = 1'b1;

    // 1: short image then read back
    load_word(16'h1111);
    load_word(16'h2222);
    load_word(16'h3333);
    load_mode = 1'b0;
    read_word("t1_a0", 5'd0, 16'h1111);
    read_word("t1_a1", 5'd1, 16'h2222);
    read_word("t1_a2", 5'd2, 16'h3333);

    // 2: full image, wrap
    for (int i = 0; i < 31; i++) load_word(16'h1000 + 16'(i));
    check_val("t2_full_31", load_full, 0);
    load_word(16'h101F);
    check_val("t2_full_32", load_full, 1);
    load_word(16'hBEEF);
    check_val("t2_full_33", load_full, 1);
    load_mode = 1'b0;
    tick();
    check_val("t2_full_run", load_full, 0);
    read_word("t2_a0", 5'd0, 16'hBEEF);
    read_word("t2_a31", 5'd31, 16'h101F);

    // 3: write then read; read captured before a later write
    write_word(5'd5, 16'hA5A5);
    read_word("t3_a5", 5'd5, 16'hA5A5);
    mem_read = 1'b1; mem_address = 5'd7;
    tick();
    mem_read = 1'b0;
    mem_write = 1'b1; mem_write_data = 16'h0F0F;
    tick();
    mem_write = 1'b0;
    tick();
    check_val("t3_raw_ready", mem_ready, 1);
    check_val("t3_raw_old", mem_read_data, 16'h1007);
    tick();
    read_word("t3_a7_new", 5'd7, 16'h0F0F);

    // 4: read+write collision
    mem_read = 1'b1; mem_write = 1'b1; mem_address = 5'd4; mem_write_data = 16'h0042;
    tick();
    mem_read = 1'b0; mem_write = 1'b0;
    seen = 0;
    repeat (5) begin
      seen += int'(mem_ready);
      tick();
    end
    check_val("t4_no_ready", seen, 0);
    check_val("t4_err", access_error, 1);
    read_word("t4_a4", 5'd4, 16'h0042);
    check_val("t4_err_sticky", access_error, 1);

    // 5: back-to-back reads
    for (int c = 0; c < 6; c++) begin
      if (c < 4) begin
        mem_read = 1'b1;
        mem_address = 5'(c);
      end else begin
        mem_read = 1'b0;
      end
      tick();
      if (c >= LAT - 1) begin
        check_val($sformatf("t5_ready%0d", c), mem_ready, 1);
        check_val($sformatf("t5_data%0d", c), mem_read_data, exp5[c-LAT+1]);
      end
    end
    tick();
    check_val("t5_idle", mem_ready, 0);

    // 5b: reset mid-stream
    for (int c = 0; c < 3; c++) begin
      mem_read = 1'b1;
      mem_address = 5'(c);
      tick();
    end
    mem_read = 1'b0;
    check_val("t5b_pre_ready", mem_ready, 1);
    check_val("t5b_pre_data", mem_read_data, 16'hBEEF);
    check_val("t5b_pre_err", access_error, 1);
    reset = 1'b0;
    #1;
    check_val("t5b_rst_ready", mem_ready, 0);
    check_val("t5b_rst_data", mem_read_data, 0);
    check_val("t5b_rst_err", access_error, 0);
    tick();
    reset = 1'b1;
    tick();
    read_word("t5b_a2", 5'd2, 16'h1002);
    read_word("t5b_a31", 5'd31, 16'h101F);

    // 6: flush on RUN->LOAD, then strobe while loading
    mem_read = 1'b1; mem_address = 5'd1;
    tick();
    mem_read = 1'b0;
    load_mode = 1'b1;
    seen = 0;
    repeat (4) begin
      tick();
      seen += int'(mem_ready);
    end
    check_val("t6_flush", seen, 0);
    check_val("t6_flush_err", access_error, 0);
    mem_read = 1'b1; mem_address = 5'd2;
    tick();
    mem_read = 1'b0;
    check_val("t6_err", access_error, 1);
    seen = 0;
    repeat (3) begin
      tick();
      seen += int'(mem_ready);
    end
    check_val("t6_no_ready", seen, 0);
    load_word(16'h7777);
    load_mode = 1'b0;
    read_word("t6_ptr_a0", 5'd0, 16'h7777);
    read_word("t6_ptr_a1", 5'd1, 16'h1001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
